// File: rtl/dcf_time_pkg.sv
// Shared field layout, reset date and calendar helpers for the DCF77 time keeper.
// The 44-bit word is BCD, MSB first: year, month, day, weekday, hour, minute, second, 2'b00.
package dcf_time_pkg;

    localparam int unsigned YEAR_MSB  = 43;
    localparam int unsigned YEAR_LSB  = 36;
    localparam int unsigned MONTH_MSB = 35;
    localparam int unsigned MONTH_LSB = 31;
    localparam int unsigned DAY_MSB   = 30;
    localparam int unsigned DAY_LSB   = 25;
    localparam int unsigned WDAY_MSB  = 24;
    localparam int unsigned WDAY_LSB  = 22;
    localparam int unsigned HOUR_MSB  = 21;
    localparam int unsigned HOUR_LSB  = 16;
    localparam int unsigned MIN_MSB   = 15;
    localparam int unsigned MIN_LSB   = 9;

    // Power-up date is Saturday 2000-01-01 00:00:00.
    localparam logic [7:0] RST_YEAR  = 8'h00;
    localparam logic [4:0] RST_MONTH = 5'h01;
    localparam logic [5:0] RST_DAY   = 6'h01;
    localparam logic [2:0] RST_WDAY  = 3'd6;
    localparam logic [5:0] RST_HOUR  = 6'h00;
    localparam logic [6:0] RST_MIN   = 7'h00;
    localparam logic [6:0] RST_SEC   = 7'h00;

    // Leap test on the BCD digits: divisible by four within 00..99.
    function automatic logic is_leap(input logic [7:0] year_bcd);
        logic w_leap;
        if (year_bcd[4] == 1'b0) begin
            w_leap = (year_bcd[3:0] == 4'd0) || (year_bcd[3:0] == 4'd4) ||
                     (year_bcd[3:0] == 4'd8);
        end else begin
            w_leap = (year_bcd[3:0] == 4'd2) || (year_bcd[3:0] == 4'd6);
        end
        return w_leap;
    endfunction

    function automatic logic [5:0] days_in_month(input logic [4:0] month_bcd, input logic leap);
        logic [5:0] w_days;
        case (month_bcd)
            5'h04, 5'h06, 5'h09, 5'h11: w_days = 6'h30;
            5'h02:                      w_days = leap ? 6'h29 : 6'h28;
            default:                    w_days = 6'h31;
        endcase
        return w_days;
    endfunction

endpackage

// File: rtl/dcf_time_keeper_bcd_wrap_counter.sv
// Two-digit BCD counter that wraps from max_val to min_val with a combinational carry,
// so a chain of instances resolves a full calendar roll-over in one clock.
module bcd_wrap_counter #(
    parameter int unsigned W         = 8,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] max_val,
    input  logic [W-1:0] min_val,
    output logic [W-1:0] value,
    output logic         carry_out
);
    localparam int unsigned TW = W - 4;

    logic [W-1:0]  r_value;
    logic [W-1:0]  w_next;
    logic [TW-1:0] w_tens_inc;

    // Using >= lets an out-of-range loaded value fall back to min_val at its next step.
    assign carry_out  = inc & (r_value >= max_val);
    assign w_tens_inc = r_value[W-1:4] + TW'(1);
    assign value      = r_value;

    // Next-value selection: wrap, ones-digit carry into tens, or plain increment.
    always_comb begin
        w_next = r_value;
        if (carry_out) begin
            w_next = min_val;
        end else if (inc) begin
            if (r_value[3:0] >= 4'd9) begin
                w_next = {w_tens_inc, 4'd0};
            end else begin
                w_next = {r_value[W-1:4], r_value[3:0] + 4'd1};
            end
        end else begin
            w_next = r_value;
        end
    end

    // Value register; load has priority over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= RESET_VAL;
        end else if (load) begin
            r_value <= load_val;
        end else begin
            r_value <= w_next;
        end
    end

endmodule

// File: rtl/dcf_time_keeper.sv
// Free-running BCD calendar clock: loads the DCF77 word at valid minute marks, advances
// once per second strobe, and flags loss of sync after a holdover period without loads.
module dcf_time_keeper
    import dcf_time_pkg::*;
#(
    parameter int unsigned HOLDOVER_MIN = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en_1hz,
    input  logic        minute_start_in,
    input  logic [43:0] timeAndDate_in,
    input  logic        data_valid,
    output logic [43:0] timeAndDate_out,
    output logic        synced,
    output logic        sec_tick,
    output logic        min_tick
);
    localparam logic [7:0] HOLD_LIMIT = 8'(HOLDOVER_MIN);

    logic       w_load;
    logic       w_tick;
    logic       w_sec_carry;
    logic       w_min_carry;
    logic       w_hour_carry;
    logic       w_day_carry;
    logic       w_month_carry;
    logic       w_year_carry;
    logic [6:0] w_sec;
    logic [6:0] w_min;
    logic [5:0] w_hour;
    logic [5:0] w_day;
    logic [4:0] w_month;
    logic [7:0] w_year;
    logic [5:0] w_dim;
    logic       w_unused_low;

    logic [2:0] r_wday;
    logic [7:0] r_hold;
    logic       r_synced;
    logic       r_sec_tick;
    logic       r_min_tick;

    assign w_load       = minute_start_in & data_valid;
    assign w_tick       = clk_en_1hz & ~w_load;
    assign w_dim        = days_in_month(w_month, is_leap(w_year));
    assign w_unused_low = &{1'b0, timeAndDate_in[8:0], w_year_carry};

    bcd_wrap_counter #(.W(7), .RESET_VAL(RST_SEC)) u_sec (
        .clk(clk), .reset(reset), .inc(w_tick), .load(w_load), .load_val(7'h00),
        .max_val(7'h59), .min_val(7'h00), .value(w_sec), .carry_out(w_sec_carry)
    );

    bcd_wrap_counter #(.W(7), .RESET_VAL(RST_MIN)) u_min (
        .clk(clk), .reset(reset), .inc(w_sec_carry), .load(w_load),
        .load_val(timeAndDate_in[MIN_MSB:MIN_LSB]),
        .max_val(7'h59), .min_val(7'h00), .value(w_min), .carry_out(w_min_carry)
    );

    bcd_wrap_counter #(.W(6), .RESET_VAL(RST_HOUR)) u_hour (
        .clk(clk), .reset(reset), .inc(w_min_carry), .load(w_load),
        .load_val(timeAndDate_in[HOUR_MSB:HOUR_LSB]),
        .max_val(6'h23), .min_val(6'h00), .value(w_hour), .carry_out(w_hour_carry)
    );

    bcd_wrap_counter #(.W(6), .RESET_VAL(RST_DAY)) u_day (
        .clk(clk), .reset(reset), .inc(w_hour_carry), .load(w_load),
        .load_val(timeAndDate_in[DAY_MSB:DAY_LSB]),
        .max_val(w_dim), .min_val(6'h01), .value(w_day), .carry_out(w_day_carry)
    );

    bcd_wrap_counter #(.W(5), .RESET_VAL(RST_MONTH)) u_month (
        .clk(clk), .reset(reset), .inc(w_day_carry), .load(w_load),
        .load_val(timeAndDate_in[MONTH_MSB:MONTH_LSB]),
        .max_val(5'h12), .min_val(5'h01), .value(w_month), .carry_out(w_month_carry)
    );

    bcd_wrap_counter #(.W(8), .RESET_VAL(RST_YEAR)) u_year (
        .clk(clk), .reset(reset), .inc(w_month_carry), .load(w_load),
        .load_val(timeAndDate_in[YEAR_MSB:YEAR_LSB]),
        .max_val(8'h99), .min_val(8'h00), .value(w_year), .carry_out(w_year_carry)
    );

    // Weekday, holdover tracking and strobe outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wday     <= RST_WDAY;
            r_hold     <= 8'd0;
            r_synced   <= 1'b0;
            r_sec_tick <= 1'b0;
            r_min_tick <= 1'b0;
        end else begin
            r_sec_tick <= w_tick;
            r_min_tick <= w_load | w_sec_carry;
            if (w_load) begin
                r_wday   <= timeAndDate_in[WDAY_MSB:WDAY_LSB];
                r_hold   <= 8'd0;
                r_synced <= 1'b1;
            end else begin
                if (w_hour_carry) begin
                    r_wday <= (r_wday >= 3'd7) ? 3'd1 : r_wday + 3'd1;
                end
                if (w_sec_carry && (r_hold != HOLD_LIMIT)) begin
                    r_hold <= r_hold + 8'd1;
                end
                // Sync drops the cycle after the counter has reached the limit.
                if (r_hold == HOLD_LIMIT) begin
                    r_synced <= 1'b0;
                end
            end
        end
    end

    assign timeAndDate_out = {w_year, w_month, w_day, r_wday, w_hour, w_min, w_sec, 2'b00};
    assign synced          = r_synced;
    assign sec_tick        = r_sec_tick;
    assign min_tick        = r_min_tick;

endmodule

// File: tb/tb_dcf_time_keeper.sv
// Self-checking bench for dcf_time_keeper: integer calendar model feeding a scoreboard,
// a table of load/roll-over vectors, and hand sequences for coincidence, holdover and reset.
module tb_dcf_time_keeper;
    localparam int HMIN = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_en_1hz = 1'b0;
    logic        minute_start_in = 1'b0;
    logic        data_valid = 1'b0;
    logic [43:0] timeAndDate_in = 44'd0;
    logic [43:0] timeAndDate_out;
    logic        synced;
    logic        sec_tick;
    logic        min_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcf_time_keeper #(.HOLDOVER_MIN(HMIN)) dut (
        .clk(clk), .reset(reset), .clk_en_1hz(clk_en_1hz),
        .minute_start_in(minute_start_in), .timeAndDate_in(timeAndDate_in),
        .data_valid(data_valid), .timeAndDate_out(timeAndDate_out),
        .synced(synced), .sec_tick(sec_tick), .min_tick(min_tick)
    );

    typedef struct {
        logic [43:0] word;
        logic        sync;
        logic        st;
        logic        mt;
    } exp_t;

    typedef struct {
        logic [43:0] ld;
        logic [43:0] exp;
    } vec_t;

    exp_t sb_q[$];

    int   m_yy, m_mo, m_dd, m_wd, m_hh, m_mi, m_ss, m_hold;
    logic m_sync;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [43:0] mk(input int yy, mo, dd, wd, hh, mi, ss);
        logic [7:0] y, m, d, h, n, s;
        y = to_bcd(yy); m = to_bcd(mo); d = to_bcd(dd);
        h = to_bcd(hh); n = to_bcd(mi); s = to_bcd(ss);
        return {y, m[4:0], d[5:0], 3'(wd), h[5:0], n[6:0], s[6:0], 2'b00};
    endfunction

    function automatic int dim(input int mo, input int yy);
        case (mo)
            4, 6, 9, 11: return 30;
            2:           return (yy % 4 == 0) ? 29 : 28;
            default:     return 31;
        endcase
    endfunction

    task automatic model_cycle(input logic r, en, ms, dv, input logic [43:0] w, output exp_t e);
        logic mt;
        logic st;
        mt = 1'b0;
        st = 1'b0;
        if (r) begin
            m_yy = 0; m_mo = 1; m_dd = 1; m_wd = 6; m_hh = 0; m_mi = 0; m_ss = 0;
            m_hold = 0; m_sync = 1'b0;
        end else if (ms && dv) begin
            m_yy = from_bcd(w[43:36]);
            m_mo = from_bcd({3'b000, w[35:31]});
            m_dd = from_bcd({2'b00, w[30:25]});
            m_wd = int'(w[24:22]);
            m_hh = from_bcd({2'b00, w[21:16]});
            m_mi = from_bcd({1'b0, w[15:9]});
            m_ss = 0;
            m_hold = 0; m_sync = 1'b1; mt = 1'b1;
        end else begin
            if (m_hold == HMIN) m_sync = 1'b0;
            if (en) begin
                st = 1'b1;
                if (m_ss >= 59) begin
                    m_ss = 0;
                    mt = 1'b1;
                    if (m_hold != HMIN) m_hold++;
                    if (m_mi >= 59) begin
                        m_mi = 0;
                        if (m_hh >= 23) begin
                            m_hh = 0;
                            m_wd = (m_wd >= 7) ? 1 : m_wd + 1;
                            if (m_dd >= dim(m_mo, m_yy)) begin
                                m_dd = 1;
                                if (m_mo >= 12) begin
                                    m_mo = 1;
                                    m_yy = (m_yy >= 99) ? 0 : m_yy + 1;
                                end else m_mo++;
                            end else m_dd++;
                        end else m_hh++;
                    end else m_mi++;
                end else m_ss++;
            end
        end
        e.word = mk(m_yy, m_mo, m_dd, m_wd, m_hh, m_mi, m_ss);
        e.sync = m_sync;
        e.st   = st;
        e.mt   = mt;
    endtask

    task automatic check44(input string name, input logic [43:0] act, input logic [43:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, push the model's expectation, then compare after the edge.
    task automatic apply(input logic r, en, ms, dv, input logic [43:0] w);
        exp_t e;
        exp_t got;
        reset = r; clk_en_1hz = en; minute_start_in = ms; data_valid = dv; timeAndDate_in = w;
        model_cycle(r, en, ms, dv, w, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0; clk_en_1hz = 1'b0; minute_start_in = 1'b0; data_valid = 1'b0;
        got = sb_q.pop_front();
        check44("sb_word", timeAndDate_out, got.word);
        check1("sb_synced", synced, got.sync);
        check1("sb_sec_tick", sec_tick, got.st);
        check1("sb_min_tick", min_tick, got.mt);
    endtask

    initial begin
        vec_t vecs[6];
        int   n_min;
        logic [43:0] rst_word;

        vecs[0] = '{mk(24, 2, 28, 3, 23, 59, 0), mk(24, 2, 29, 4, 0, 0, 0)};
        vecs[1] = '{mk(23, 2, 28, 2, 23, 59, 0), mk(23, 3, 1, 3, 0, 0, 0)};
        vecs[2] = '{mk(99, 12, 31, 4, 23, 59, 0), mk(0, 1, 1, 5, 0, 0, 0)};
        vecs[3] = '{mk(23, 12, 31, 7, 23, 59, 0), mk(24, 1, 1, 1, 0, 0, 0)};
        vecs[4] = '{mk(24, 4, 30, 2, 23, 59, 0), mk(24, 5, 1, 3, 0, 0, 0)};
        vecs[5] = '{mk(21, 1, 32, 1, 23, 59, 0), mk(21, 2, 1, 2, 0, 0, 0)};
        rst_word = mk(0, 1, 1, 6, 0, 0, 0);

        apply(1'b1, 1'b0, 1'b0, 1'b0, 44'd0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 44'd0);
        check44("reset_word", timeAndDate_out, rst_word);
        check1("reset_synced", synced, 1'b0);

        // A minute mark without valid data, or valid data without a mark, must not load.
        apply(1'b0, 1'b0, 1'b1, 1'b0, vecs[0].ld);
        apply(1'b0, 1'b0, 1'b0, 1'b1, vecs[0].ld);
        check44("no_load_word", timeAndDate_out, rst_word);

        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b1, vecs[i].ld);
            n_min = 0;
            for (int t = 0; t < 60; t++) begin
                apply(1'b0, 1'b1, 1'b0, 1'b0, 44'd0);
                if (min_tick === 1'b1) n_min++;
            end
            check44($sformatf("vec%0d_word", i), timeAndDate_out, vecs[i].exp);
            check1($sformatf("vec%0d_one_min_tick", i), n_min == 1, 1'b1);
            check1($sformatf("vec%0d_synced", i), synced, 1'b1);
        end

        // Load and tick coincide at second 37: load wins, no sec_tick.
        apply(1'b0, 1'b0, 1'b1, 1'b1, mk(24, 2, 28, 3, 10, 20, 0));
        for (int t = 0; t < 37; t++) apply(1'b0, 1'b1, 1'b0, 1'b0, 44'd0);
        check44("at_sec37", timeAndDate_out, mk(24, 2, 28, 3, 10, 20, 37));
        apply(1'b0, 1'b1, 1'b1, 1'b1, mk(24, 2, 28, 3, 10, 45, 0));
        check44("coincide_word", timeAndDate_out, mk(24, 2, 28, 3, 10, 45, 0));
        check1("coincide_sec_tick", sec_tick, 1'b0);
        check1("coincide_min_tick", min_tick, 1'b1);

        // Holdover: synced drops the cycle after the second tick-induced min_tick.
        apply(1'b0, 1'b0, 1'b1, 1'b1, mk(22, 6, 15, 3, 8, 0, 0));
        for (int t = 0; t < 119; t++) apply(1'b0, 1'b1, 1'b0, 1'b0, 44'd0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 44'd0);
        check1("hold_2nd_min_tick", min_tick, 1'b1);
        check1("hold_still_synced", synced, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 44'd0);
        check1("hold_lost_sync", synced, 1'b0);
        check44("hold_word", timeAndDate_out, mk(22, 6, 15, 3, 8, 2, 0));
        apply(1'b0, 1'b0, 1'b1, 1'b1, mk(22, 6, 15, 3, 9, 0, 0));
        check1("hold_resync", synced, 1'b1);

        // Reset right after a load, then reset with concurrent strobes, then check nothing queued.
        apply(1'b0, 1'b0, 1'b1, 1'b1, mk(30, 7, 4, 4, 12, 34, 0));
        apply(1'b1, 1'b1, 1'b0, 1'b0, 44'd0);
        check44("rst_after_load_word", timeAndDate_out, rst_word);
        check1("rst_after_load_synced", synced, 1'b0);
        apply(1'b1, 1'b1, 1'b1, 1'b1, mk(30, 7, 4, 4, 12, 34, 0));
        apply(1'b0, 1'b0, 1'b0, 1'b0, 44'd0);
        check44("rst_drop_word", timeAndDate_out, rst_word);
        check1("rst_drop_min_tick", min_tick, 1'b0);
        check1("rst_drop_sec_tick", sec_tick, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcf_time_keeper.md
# dcf_time_keeper

Free-running BCD time-and-date clock downstream of `dcf77_decoder`. It loads the decoded 44-bit time word at each valid minute mark and advances it once per `clk_en_1hz` pulse, handling calendar roll-over and leap years. When DCF reception drops out it keeps running and reports that it is no longer synchronised. Its outputs feed the display and alarm logic.

## Interface
- `HOLDOVER_MIN`, 60: full minutes without a successful load before `synced` is cleared (1..255).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `clk_en_1hz`  in  1  one-cycle second strobe from `GenClockDCF`.
- `minute_start_in`  in  1  one-cycle minute-mark strobe from `GenClockDCF`.
- `timeAndDate_in`  in  44  decoder word; stable while `data_valid` is high.
- `data_valid`  in  1  decoder word is parity-checked and complete.
- `timeAndDate_out`  out  44  running time, same format as input.
- `synced`  out  1  time is derived from a load within the holdover window.
- `sec_tick`  out  1  one-cycle pulse when `timeAndDate_out` advanced by a tick.
- `min_tick`  out  1  one-cycle pulse on the seconds 59→00 carry or on a load.

## Operation
- Word format (BCD, MSB first): [43:36] year 00–99 (2000–2099); [35:31] month 01–12; [30:25] day 01–31; [24:22] weekday 1=Mon..7=Sun; [21:16] hour 00–23; [15:9] minute 00–59; [8:2] second 00–59; [1:0] always 00. The decoder drives [8:0] as 0.
- Load condition: `minute_start_in & data_valid` in the same cycle. Copy [43:9] from the input, set second to 00, clear the holdover counter, set `synced` to 1, and pulse `min_tick`.
- Tick: `clk_en_1hz` with no load in that cycle. Increment second. Carry chain: second 59→00 increments minute; minute 59→00 increments hour; hour 23→00 increments day and weekday (7→1); day equal to days-in-month rolls to 01 and increments month; month 12→01 increments year; year 99→00.
- Days-in-month: 31 for months 01, 03, 05, 07, 08, 10, 12; 30 for months 04, 06, 09, 11; 29 for month 02 in a leap year, else 28.
- Leap year, decided on the BCD digits: tens digit even and ones digit ∈ {0,4,8}, or tens digit odd and ones digit ∈ {2,6}.
- Every BCD digit wraps 9→0 with a carry into the next digit. Digits never take values A–F.
- Out-of-range loaded values (e.g. day 32): no check is made. The counters run from the loaded value and reach a legal value at the next wrap. The decoder is responsible for range checking.
- Holdover: an 8-bit counter increments on every `min_tick` caused by a tick. When it reaches `HOLDOVER_MIN`, `synced` goes to 0 and the counter saturates.
- Reset values: time = 2000-01-01, weekday 6 (Saturday), 00:00:00, i.e. year 00, month 01, day 01, hour/min/sec 00. `synced` = 0, holdover counter = 0, `sec_tick` = 0, `min_tick` = 0.

## Timing
- All outputs are registered.
- Load and tick each take effect on the clock edge after the strobe, so outputs show the result one cycle later. `sec_tick` and `min_tick` are asserted in that same cycle.
- Load and tick in the same cycle: the load wins, the second becomes 00, and `sec_tick` stays 0.
- The whole carry chain resolves in one cycle (combinational ripple). No multi-cycle roll-over.
- `reset` asserted mid-operation: all state returns to reset values on the next edge. A concurrent load or tick is ignored.
- Strobes arriving while `reset` is high are dropped and are not queued.

## Structure
- Package `dcf_time_pkg`: field bit-positions/localparams for the 44-bit word, reset-date constants, `days_in_month(month_bcd, leap)` function, `is_leap(year_bcd)` function.
- Sub-module `bcd_wrap_counter`: parameterised two-digit BCD counter with `inc`, `load`, `load_val`, `max_val`, `min_val`. Outputs the value and `carry_out`. One instance each for second, minute, hour, day, month and year; weekday is a 3-bit counter in the top level.

## Test plan
- Reset → `timeAndDate_out` = year 00, month 01, day 01, weekday 6, 00:00:00; `synced` = 0.
- Load 2024-02-28 Wed(3) 23:59, then 60 ticks → 2024-02-29 Thu(4) 00:00:00, `min_tick` once, `synced` = 1.
- Load 2023-02-28 23:59, 60 ticks → 2023-03-01 00:00:00. Load 2099-12-31 Thu(4) 23:59, 60 ticks → 2000-01-01 Fri(5) 00:00:00.
- At second 37, `clk_en_1hz` and a load coincide → loaded minute with second 00; `sec_tick` = 0, `min_tick` = 1.
- `HOLDOVER_MIN` = 2: load, then 120 ticks with no load → `synced` falls exactly on the cycle after the 2nd tick-induced `min_tick`. A subsequent load → `synced` = 1.
- Assert `reset` one cycle after a load strobe → outputs equal the reset values and the load is not applied.
